// File: rtl/dec_is_queue_pkg.sv
// dec_is_queue_pkg: shared CPU types for the decode-to-issue path (widths, decoded op, queue entry).
package dec_is_queue_pkg;
  localparam int AddrWidth = 32;
  localparam int DataWidth = 32;
  localparam int RegIdxW   = 5;
  localparam int OP_W      = 3;
  typedef enum logic [OP_W-1:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_LOAD, OP_STORE
  } op_e;
  typedef struct packed {
    logic [AddrWidth-1:0] pc;
    op_e                  op;
    logic [RegIdxW-1:0]   rd;
    logic [RegIdxW-1:0]   rs1;
    logic [RegIdxW-1:0]   rs2;
    logic [DataWidth-1:0] imm;
  } entry_t;
endpackage

// File: rtl/dec_is_queue.sv
// dec_is_queue: decode-to-issue instruction FIFO with flush; outputs come only from registered state.
module dec_is_queue
  import dec_is_queue_pkg::*;
#(
  parameter int ADDR  = AddrWidth,
  parameter int DATA  = DataWidth,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [ADDR-1:0]      dec_pc,
  input  op_e                  dec_op,
  input  logic [RegIdxW-1:0]   dec_rd,
  input  logic [RegIdxW-1:0]   dec_rs1,
  input  logic [RegIdxW-1:0]   dec_rs2,
  input  logic [DATA-1:0]      dec_imm,
  output logic                 is_valid,
  input  logic                 is_ready,
  output logic [ADDR-1:0]      is_pc,
  output op_e                  is_op,
  output logic [RegIdxW-1:0]   is_rd,
  output logic [RegIdxW-1:0]   is_rs1,
  output logic [RegIdxW-1:0]   is_rs2,
  output logic [DATA-1:0]      is_imm
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef struct packed {
    logic [ADDR-1:0]    pc;
    op_e                op;
    logic [RegIdxW-1:0] rd;
    logic [RegIdxW-1:0] rs1;
    logic [RegIdxW-1:0] rs2;
    logic [DATA-1:0]    imm;
  } ent_t;
  ent_t          mem_q [DEPTH];
  ent_t          head;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;
  assign dec_ready = count_q != FULL;
  assign is_valid  = count_q != '0;
  assign push      = dec_valid & dec_ready & ~flush;
  assign pop       = is_valid & is_ready & ~flush;
  always_comb begin
    count_d = flush ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
    head_d  = flush ? '0 : head_q + PW'(pop);
    tail_d  = flush ? '0 : tail_q + PW'(push);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end
  // Storage is deliberately unreset; is_valid qualifies whatever it holds.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm};
  end
  assign head   = mem_q[head_q];
  assign is_pc  = head.pc;
  assign is_op  = head.op;
  assign is_rd  = head.rd;
  assign is_rs1 = head.rs1;
  assign is_rs2 = head.rs2;
  assign is_imm = head.imm;
endmodule

// File: tb/tb_dec_is_queue.sv
// tb_dec_is_queue: directed table, hand sequences and randomized traffic against a queue model.
module tb_dec_is_queue;
  import dec_is_queue_pkg::*;
  logic clk = 0, reset = 1, flush = 0, dec_valid = 0, is_ready = 0;
  logic [31:0] dec_pc = 0, dec_imm = 0;
  op_e dec_op = OP_ADD;
  logic [4:0] dec_rd = 0, dec_rs1 = 0, dec_rs2 = 0;
  logic dec_ready, is_valid;
  logic [31:0] is_pc, is_imm;
  op_e is_op;
  logic [4:0] is_rd, is_rs1, is_rs2;
  int n_cmp = 0, n_bad = 0;

  dec_is_queue #(.ADDR(32), .DATA(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .is_valid(is_valid), .is_ready(is_ready), .is_pc(is_pc), .is_op(is_op),
    .is_rd(is_rd), .is_rs1(is_rs1), .is_rs2(is_rs2), .is_imm(is_imm));

  always #5 clk = ~clk;

  typedef struct {
    logic fl, dv, ir;
    logic [31:0] pc;
    logic ev, er;
    logic [31:0] epc;
  } vec_t;
  typedef struct packed {
    logic [31:0] pc;
    op_e op;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
  } rec_t;

  vec_t tv [18];
  rec_t mq [$];
  rec_t r;

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{0, 1, 0, 32'h100, 1, 1, 32'h100};
    tv[1]  = '{0, 1, 0, 32'h104, 1, 1, 32'h100};
    tv[2]  = '{0, 1, 0, 32'h108, 1, 1, 32'h100};
    tv[3]  = '{0, 1, 0, 32'h10C, 1, 0, 32'h100};
    tv[4]  = '{0, 1, 0, 32'h110, 1, 0, 32'h100};
    tv[5]  = '{0, 1, 1, 32'h110, 1, 1, 32'h104};
    tv[6]  = '{0, 1, 0, 32'h110, 1, 0, 32'h104};
    tv[7]  = '{0, 0, 1, 32'h0,   1, 1, 32'h108};
    tv[8]  = '{0, 0, 1, 32'h0,   1, 1, 32'h10C};
    tv[9]  = '{0, 0, 1, 32'h0,   1, 1, 32'h110};
    tv[10] = '{0, 0, 1, 32'h0,   0, 1, 32'h0};
    tv[11] = '{0, 1, 1, 32'h400, 1, 1, 32'h400};
    tv[12] = '{0, 0, 1, 32'h0,   0, 1, 32'h0};
    tv[13] = '{0, 1, 0, 32'h500, 1, 1, 32'h500};
    tv[14] = '{0, 1, 0, 32'h504, 1, 1, 32'h500};
    tv[15] = '{0, 1, 0, 32'h508, 1, 1, 32'h500};
    tv[16] = '{1, 1, 0, 32'h300, 0, 1, 32'h0};
    tv[17] = '{0, 0, 1, 32'h0,   0, 1, 32'h0};
    step();
    step();
    chk("reset_valid", 128'(is_valid), 128'(0));
    chk("reset_ready", 128'(dec_ready), 128'(1));
    reset = 0;
    step();
    for (int i = 0; i < 18; i++) begin
      flush = tv[i].fl; dec_valid = tv[i].dv; is_ready = tv[i].ir; dec_pc = tv[i].pc;
      step();
      chk($sformatf("tbl%0d_valid", i), 128'(is_valid), 128'(tv[i].ev));
      chk($sformatf("tbl%0d_ready", i), 128'(dec_ready), 128'(tv[i].er));
      if (tv[i].ev) chk($sformatf("tbl%0d_pc", i), 128'(is_pc), 128'(tv[i].epc));
    end
    flush = 0; is_ready = 0; dec_valid = 1;
    dec_pc = 32'h600; step();
    dec_pc = 32'h604; step();
    is_ready = 1;
    for (int i = 0; i < 10; i++) begin
      dec_pc = 32'h200 + 32'(4 * i);
      step();
      chk($sformatf("steady%0d_ready", i), 128'(dec_ready), 128'(1));
      chk($sformatf("steady%0d_pc", i), 128'(is_pc), 128'(i == 0 ? 32'h604 : 32'h200 + 32'(4 * (i - 1))));
    end
    dec_valid = 0; is_ready = 0;
    step();
    chk("pre_rst_pc", 128'(is_pc), 128'(32'h220));
    #2 reset = 1;
    #1;
    chk("async_rst_valid", 128'(is_valid), 128'(0));
    chk("async_rst_ready", 128'(dec_ready), 128'(1));
    #1 reset = 0;
    dec_valid = 1; dec_pc = 32'h700;
    step();
    dec_valid = 0;
    chk("post_rst_pc", 128'(is_pc), 128'(32'h700));
    is_ready = 1;
    step();
    chk("post_rst_empty", 128'(is_valid), 128'(0));
    is_ready = 0;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      flush = $urandom_range(0, 99) < 4;
      dec_valid = $urandom_range(0, 99) < 60;
      is_ready = $urandom_range(0, 99) < 45;
      r.pc = $urandom; r.op = op_e'($urandom_range(0, 7)); r.rd = 5'($urandom);
      r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.imm = $urandom;
      {dec_pc, dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm} = r;
      if (flush) mq.delete();
      else begin
        logic do_push;
        do_push = dec_valid && mq.size() < 4;
        if (is_ready && mq.size() != 0) void'(mq.pop_front());
        if (do_push) mq.push_back(r);
      end
      step();
      chk("rnd_valid", 128'(is_valid), 128'(mq.size() != 0));
      chk("rnd_ready", 128'(dec_ready), 128'(mq.size() < 4));
      if (mq.size() != 0)
        chk("rnd_head", 128'({is_pc, is_op, is_rd, is_rs1, is_rs2, is_imm}), 128'(mq[0]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
